// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm
//  Purpose  : Main control state machine for the multicycle MIPS-subset
//             datapath. Steps each instruction through fetch, decode,
//             execute, memory and writeback, and drives the enables and
//             mux selects of the PC, IR and datapath registers.
//  Ports    : CLK, RST (sync, active-high)
//             Op[5:0], Funct[5:0]  - fields from the instruction register
//             Zero                 - ALU zero flag, current cycle
//             PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//             ALUSrcA, ALUSrcB[1:0], ALUControl[2:0], PCSrc[1:0]
//                                  - datapath controls
//             IllegalOp            - one-cycle unsupported-instruction flag
//             State[3:0]           - current state (debug)
//  Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic [3:0] State
);

  // State encodings
  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXECUTE = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       pc_write;
  logic       branch;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       op_legal;

  // R-type funct decode; unsupported functs are flagged illegal in DECODE
  // so the default ALU op here is never used by a legal instruction.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (Op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_RTYPE:                            op_legal = funct_ok;
      default:                             op_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (!op_legal) begin
          state_next = S_FETCH;
        end else begin
          case (Op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_RTYPE:     state_next = S_EXECUTE;
            OP_BEQ:       state_next = S_BRANCH;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_J:         state_next = S_JUMP;
            default:      state_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (Op == OP_LW)      state_next = S_MEMRD;
        else if (Op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;  // terminal states and unused codes
    endcase
  end

  // Reset overrides any in-flight instruction at the sampling edge.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_RESET;
    else     state <= state_next;
  end

  // Output decode (Moore, except IllegalOp and PCEn use current inputs)
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    IllegalOp  = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite = 1'b1;
        pc_write = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        PCSrc    = 2'b10;
      end
      default: begin
        // RESET and unused encodings drive everything low, ALU op included.
        ALUControl = 3'b000;
      end
    endcase
  end

  assign PCEn  = pc_write | (branch & Zero);
  assign State = state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control_fsm
//  Purpose  : Directed self-checking bench for mc_control_fsm. Walks each
//             supported instruction class plus reset and illegal cases,
//             checking State and all control outputs every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       IllegalOp;
  logic [3:0] State;

  int n_checks = 0;
  int n_errors = 0;

  mc_control_fsm dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 CLK = ~CLK;

  // Observed control word, same field order as mk() below
  logic [15:0] outs;
  assign outs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUControl, PCSrc, IllegalOp};

  function automatic logic [15:0] mk(
    input logic pcen, iord, mw, irw, rd, m2r, rw, sa,
    input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] ps,
    input logic ill);
    return {pcen, iord, mw, irw, rd, m2r, rw, sa, sb, ac, ps, ill};
  endfunction

  // Hand-derived expected control words per state
  logic [15:0] E_RESET, E_FETCH, E_DECODE, E_DEC_ILL, E_MEMADR, E_MEMRD,
               E_MEMWB, E_MEMWR, E_ALUWB, E_BR_T, E_BR_NT, E_ADDIEX,
               E_ADDIWB, E_JUMP;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [15:0] exp_outs);
    check({tag, ".state"}, {28'd0, State}, {28'd0, st});
    check({tag, ".outs"}, {16'd0, outs}, {16'd0, exp_outs});
    step();
  endtask

  // Load the next instruction fields while in FETCH.
  task automatic load(input logic [5:0] op, input logic [5:0] fn,
                      input logic z);
    Op = op; Funct = fn; Zero = z;
  endtask

  initial begin
    E_RESET   = 16'd0;
    E_FETCH   = mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0);
    E_DECODE  = mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0);
    E_DEC_ILL = mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,1);
    E_MEMADR  = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
    E_MEMRD   = mk(0,1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0);
    E_MEMWB   = mk(0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0);
    E_MEMWR   = mk(0,1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0);
    E_ALUWB   = mk(0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0);
    E_BR_T    = mk(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
    E_BR_NT   = mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
    E_ADDIEX  = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
    E_ADDIWB  = mk(0,0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0);
    E_JUMP    = mk(1,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,0);

    RST = 1'b1; Op = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    step(); step(); step();
    cyc("reset", 4'd0, E_RESET);
    RST = 1'b0;
    // cyc above advanced one edge with RST=0 already sampled? No: RST was
    // cleared after that edge, so the next edge is the first with RST=0.
    cyc("reset_hold", 4'd0, E_RESET);

    // lw
    load(6'b100011, 6'd0, 1'b0);
    cyc("lw.fetch",  4'd1, E_FETCH);
    cyc("lw.decode", 4'd2, E_DECODE);
    cyc("lw.memadr", 4'd3, E_MEMADR);
    cyc("lw.memrd",  4'd4, E_MEMRD);
    cyc("lw.memwb",  4'd5, E_MEMWB);

    // sw
    load(6'b101011, 6'd0, 1'b0);
    cyc("sw.fetch",  4'd1, E_FETCH);
    cyc("sw.decode", 4'd2, E_DECODE);
    cyc("sw.memadr", 4'd3, E_MEMADR);
    cyc("sw.memwr",  4'd6, E_MEMWR);

    // R-type sub
    load(6'b000000, 6'b100010, 1'b0);
    cyc("sub.fetch",   4'd1, E_FETCH);
    cyc("sub.decode",  4'd2, E_DECODE);
    cyc("sub.execute", 4'd7, mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0));
    cyc("sub.aluwb",   4'd8, E_ALUWB);

    // R-type slt / or: exercise other funct codes in EXECUTE
    load(6'b000000, 6'b101010, 1'b0);
    cyc("slt.fetch",   4'd1, E_FETCH);
    cyc("slt.decode",  4'd2, E_DECODE);
    cyc("slt.execute", 4'd7, mk(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0));
    cyc("slt.aluwb",   4'd8, E_ALUWB);
    load(6'b000000, 6'b100101, 1'b0);
    cyc("or.fetch",    4'd1, E_FETCH);
    cyc("or.decode",   4'd2, E_DECODE);
    cyc("or.execute",  4'd7, mk(0,0,0,0,0,0,0,1,2'b00,3'b001,2'b00,0));
    cyc("or.aluwb",    4'd8, E_ALUWB);

    // beq taken, then not taken
    load(6'b000100, 6'd0, 1'b1);
    cyc("beqT.fetch",  4'd1, E_FETCH);
    cyc("beqT.decode", 4'd2, E_DECODE);
    cyc("beqT.branch", 4'd9, E_BR_T);
    load(6'b000100, 6'd0, 1'b0);
    cyc("beqN.fetch",  4'd1, E_FETCH);
    cyc("beqN.decode", 4'd2, E_DECODE);
    cyc("beqN.branch", 4'd9, E_BR_NT);

    // j
    load(6'b000010, 6'd0, 1'b0);
    cyc("j.fetch",  4'd1, E_FETCH);
    cyc("j.decode", 4'd2, E_DECODE);
    cyc("j.jump",   4'd12, E_JUMP);

    // addi
    load(6'b001000, 6'd0, 1'b0);
    cyc("addi.fetch",  4'd1, E_FETCH);
    cyc("addi.decode", 4'd2, E_DECODE);
    cyc("addi.ex",     4'd10, E_ADDIEX);
    cyc("addi.wb",     4'd11, E_ADDIWB);

    // Illegal opcode and illegal R-type funct: two cycles each
    load(6'b111111, 6'd0, 1'b0);
    cyc("illop.fetch",  4'd1, E_FETCH);
    cyc("illop.decode", 4'd2, E_DEC_ILL);
    load(6'b000000, 6'b000111, 1'b0);
    cyc("illfn.fetch",  4'd1, E_FETCH);
    cyc("illfn.decode", 4'd2, E_DEC_ILL);

    // Reset mid-store: RST asserted while in MEMWR
    load(6'b101011, 6'd0, 1'b0);
    cyc("swr.fetch",  4'd1, E_FETCH);
    cyc("swr.decode", 4'd2, E_DECODE);
    cyc("swr.memadr", 4'd3, E_MEMADR);
    check("swr.memwr.state", {28'd0, State}, 32'd6);
    RST = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rst_mid.state", {28'd0, State}, 32'd0);
      check("rst_mid.memwrite", {31'd0, MemWrite}, 32'd0);
      check("rst_mid.outs", {16'd0, outs}, {16'd0, E_RESET});
      if (i < 2) step();
    end
    RST = 1'b0;
    step();
    check("rst_rel.state", {28'd0, State}, 32'd1);
    check("rst_rel.irwrite", {31'd0, IRWrite}, 32'd1);
    check("rst_rel.pcen", {31'd0, PCEn}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control state machine for the multicycle datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the enables and multiplexer selects of the datapath registers: PC, instruction register, and the unconditional pass-through data/ALU registers that latch every CLK. Sits directly upstream of those registers and consumes the opcode/funct fields and ALU Zero flag they feed back.

## Interface
- No parameters; widths fixed by the 32-bit MIPS-subset ISA.
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- Op  input  6  instruction[31:26] from instruction register
- Funct  input  6  instruction[5:0] from instruction register
- Zero  input  1  ALU zero flag (combinational, current cycle)
- PCEn  output  1  PC register load enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register load enable
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = memory data register
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  output  1  one-cycle flag for an unsupported instruction
- State  output  4  current state encoding (debug)

## Operation
- Moore machine: registered 4-bit state; all outputs decoded combinationally from state. PCEn additionally uses Zero.
- Outputs not listed for a state are 0; ALUSrcB/PCSrc default 00; ALUControl default 010.
- State encodings and assertions:
  - RESET (0): all outputs 0.
  - FETCH (1): IRWrite, PCWrite, ALUSrcB=01, add.
  - DECODE (2): ALUSrcB=11, add (branch target).
  - MEMADR (3): ALUSrcA=1, ALUSrcB=10, add.
  - MEMRD (4): IorD=1.
  - MEMWB (5): RegWrite, MemtoReg=1, RegDst=0.
  - MEMWR (6): IorD=1, MemWrite.
  - EXECUTE (7): ALUSrcA=1, ALUSrcB=00, ALUControl from Funct.
  - ALUWB (8): RegWrite, RegDst=1.
  - BRANCH (9): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch.
  - ADDIEX (10): ALUSrcA=1, ALUSrcB=10, add.
  - ADDIWB (11): RegWrite, RegDst=0.
  - JUMP (12): PCWrite, PCSrc=10.
- PCEn = PCWrite | (Branch & Zero).
- Funct decode in EXECUTE: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
- Transitions:
  - RESET→FETCH; FETCH→DECODE.
  - DECODE dispatches on Op: 100011 (lw) / 101011 (sw) → MEMADR; 000000 → EXECUTE; 000100 (beq) → BRANCH; 001000 (addi) → ADDIEX; 000010 (j) → JUMP.
  - MEMADR: lw → MEMRD, sw → MEMWR.
  - MEMRD→MEMWB; EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
- Illegal instruction: in DECODE, unlisted Op, or Op=000000 with unlisted Funct.
  - Asserts IllegalOp during DECODE; next state FETCH.
  - No register or memory write occurs; PC has already advanced by 4.
- Unused encodings 13–15 decode as RESET outputs and go to FETCH.

## Timing
- RST sampled at posedge CLK only. While RST=1 the next state is RESET regardless of current state, including mid-instruction. An in-flight store or writeback is abandoned at that edge; no strobe occurs afterwards.
- First FETCH is the cycle after the first edge with RST=0.
- Cycles per instruction, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Op/Funct must be stable from DECODE onward; they are sampled every cycle, and IR loads only in FETCH.
- Zero is used combinationally in BRANCH; PC updates at the edge ending BRANCH.

## Test plan
- Reset: hold RST 3 cycles from arbitrary state (e.g. MEMWR) → State=0, all outputs 0, MemWrite never asserted after the RST edge; release → State=1 next cycle with IRWrite=PCEn=1.
- lw (Op=100011) → states 1,2,3,4,5,1; IorD=1 in 4; RegWrite & MemtoReg only in 5.
- sw, then R-type sub (Funct=100010) → sw: MemWrite only in state 6, 4 cycles; sub: ALUControl=110 in state 7, RegWrite & RegDst=1 in state 8.
- beq with Zero=1 then Zero=0 → PCEn=1 / PCEn=0 in state 9; PCSrc=01, ALUControl=110; 3 cycles each.
- j and addi → j: PCEn=1, PCSrc=10 in state 12; addi: ALUSrcB=10 in state 10, RegWrite & RegDst=0 in state 11.
- Illegal Op=111111 and R-type Funct=000111 → IllegalOp=1 for exactly the DECODE cycle, then FETCH; RegWrite/MemWrite never asserted.
